pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush inputs of the PC, IF/ID and ID/EX registers. It resolves load-use hazards and branch mispredicts, and adds a debug halt/single-step FSM that drains the pipeline. It also keeps saturating performance counters for stalls and flushes.

Parameters:
DRAIN_CYCLES, 3, cycles held in DRAIN after halt/step (covers EX, MEM, WB)
CNT_WIDTH, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous reset, active low
id_rs1_i  in  5  rs1 address of instruction in ID
id_rs2_i  in  5  rs2 address of instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  reg_wr_addr of instruction in EX
ex_reg_wr_i  in  1  reg_wr_sig of instruction in EX
ex_load_i  in  1  EX instruction is a load
br_mispredict_i  in  1  branch in EX resolved opposite to prediction (PC redirect valid this cycle)
halt_req_i  in  1  debug halt request (level, sampled in RUN)
step_i  in  1  single-step request (sampled in HALTED)
resume_i  in  1  resume request (sampled in HALTED)
pc_stall_o  out  1  hold PC
if_id_stall_o  out  1  hold IF/ID
if_id_flush_o  out  1  bubble IF/ID
id_ex_stall_o  out  1  bubble ID/EX (register inserts NOP on stall)
id_ex_flush_o  out  1  bubble ID/EX
halted_o  out  1  core halted, pipeline empty
stall_cnt_o  out  CNT_WIDTH  load-use stall cycles
flush_cnt_o  out  CNT_WIDTH  mispredict flushes

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous and active low.
- While reset_n=0: state=RUN, drain counter=0, stall_cnt_o=0, flush_cnt_o=0, halted_o=0, and every stall/flush output is forced to 0.
- State, counters and halted_o are registered. Stall/flush outputs are combinational from state and inputs, so they act in the same cycle (zero latency).
- hazard = ex_load_i & ex_reg_wr_i & (ex_rd_i!=0) & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
- Normal decode (used in RUN and STEP):
  - br_mispredict_i=1: if_id_flush_o=1, id_ex_flush_o=1, pc_stall_o=0. Mispredict wins over hazard.
  - Else hazard=1: pc_stall_o=1, if_id_stall_o=1, id_ex_stall_o=1 (one bubble; the hazard self-clears next cycle).
  - Else: all outputs 0.
- States:
  - RUN: normal decode. If halt_req_i=1, go to DRAIN and load counter=DRAIN_CYCLES. The current cycle still uses normal decode.
  - DRAIN: pc_stall_o=1, if_id_stall_o=1, id_ex_stall_o=1, so the ID instruction is held and bubbles enter EX. Exception: if br_mispredict_i=1, drive pc_stall_o=0, if_id_flush_o=1, id_ex_flush_o=1 so the redirect completes. Counter decrements every cycle; at counter==1 go to HALTED.
  - HALTED: halted_o=1 (registered, asserted the cycle after entry). pc_stall_o, if_id_stall_o and id_ex_stall_o are held at 1. resume_i=1 goes to RUN. Else step_i=1 goes to STEP. resume has priority over step. halt_req_i is ignored.
  - STEP: normal decode. If hazard=1 and br_mispredict_i=0, stay in STEP (the instruction has not advanced). Otherwise go to DRAIN with counter=DRAIN_CYCLES.
- halted_o clears on leaving HALTED.
- Counters:
  - stall_cnt increments on each cycle where hazard drives a stall under normal decode (RUN or STEP, no mispredict).
  - flush_cnt increments on each cycle with br_mispredict_i=1, in any state.
  - Both saturate at all-ones and never wrap.
- Simultaneous halt_req_i and mispredict in RUN: flush happens that cycle, then DRAIN.
- halt_req_i held high after resume: RUN immediately re-enters DRAIN on the next cycle.
- Reset asserted mid-DRAIN or mid-HALTED: immediate return to RUN, outputs 0.

Test Plan:
- Load-use: ex_load=1, ex_reg_wr=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for one cycle -> pc_stall, if_id_stall, id_ex_stall =1 for exactly that cycle; stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
- Mispredict coincident with the load-use hazard above -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
- Halt: halt_req pulse in RUN -> 3 DRAIN cycles with stalls high, halted_o=1 from the 5th edge after the request. resume -> RUN with outputs 0 next cycle.
- Single step from HALTED: step_i pulse -> one STEP cycle with outputs 0, then 3 DRAIN cycles, then HALTED. With hazard present during STEP -> STEP repeats one cycle, stall_cnt+1.
- Saturation with CNT_WIDTH=4: 20 consecutive mispredict cycles -> flush_cnt_o stays 15.
- Reset: assert reset_n=0 in DRAIN with counter=2 -> all outputs 0 immediately; after release, state RUN and counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, mispredict flush,
// debug halt/single-step drain FSM and saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [4:0]           ex_rd_i,
  input  logic                 ex_reg_wr_i,
  input  logic                 ex_load_i,
  input  logic                 br_mispredict_i,
  input  logic                 halt_req_i,
  input  logic                 step_i,
  input  logic                 resume_i,
  output logic                 pc_stall_o,
  output logic                 if_id_stall_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_stall_o,
  output logic                 id_ex_flush_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  // DRAIN_CYCLES must be at least 1; the drain counter only needs to hold that value.
  localparam int unsigned          DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]        DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic rs1_match;
  logic rs2_match;
  logic hazard;
  logic normal_decode;
  logic stall_event;
  logic hold_all;
  logic flush_all;

  // Load-use hazard: EX holds a load whose destination is read by the ID instruction.
  assign rs1_match     = id_rs1_used_i & (id_rs1_i == ex_rd_i);
  assign rs2_match     = id_rs2_used_i & (id_rs2_i == ex_rd_i);
  assign hazard        = ex_load_i & ex_reg_wr_i & (ex_rd_i != 5'd0) & (rs1_match | rs2_match);
  assign normal_decode = (state_q == S_RUN) || (state_q == S_STEP);
  assign stall_event   = normal_decode & hazard & ~br_mispredict_i;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    hold_all  = 1'b0;
    flush_all = 1'b0;
    unique case (state_q)
      S_RUN, S_STEP: begin
        flush_all = br_mispredict_i;
        hold_all  = stall_event;
      end
      S_DRAIN: begin
        // A redirect already in flight must still complete while draining.
        flush_all = br_mispredict_i;
        hold_all  = ~br_mispredict_i;
      end
      S_HALTED: hold_all = 1'b1;
      default: ;
    endcase
  end

  // Outputs are zero-latency; they are masked while reset is asserted since they are not flops.
  assign pc_stall_o    = hold_all & reset_n;
  assign if_id_stall_o = hold_all & reset_n;
  assign id_ex_stall_o = hold_all & reset_n;
  assign if_id_flush_o = flush_all & reset_n;
  assign id_ex_flush_o = flush_all & reset_n;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (halt_req_i) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - DW'(1);
        if (drain_cnt_q == DW'(1)) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (resume_i) begin
          state_d = S_RUN;
        end else if (step_i) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // A stalled step has not advanced its instruction yet, so it retries.
        if (!stall_event) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // halted_o rises one cycle after HALTED is entered and drops on the edge that leaves it.
  assign halted_d = (state_q == S_HALTED) && (state_d == S_HALTED);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_event && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (br_mispredict_i && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted_o    = halted_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus a randomized
// run, all compared against a mode-level behavioural model of the controller.
module tb_pipeline_hazard_controller;

  localparam int D    = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i;
  logic          id_rs1_used_i, id_rs2_used_i, ex_reg_wr_i, ex_load_i;
  logic          br_mispredict_i, halt_req_i, step_i, resume_i;
  logic          pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o;
  logic          halted_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_controller #(.DRAIN_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_rs1_used_i   (id_rs1_used_i),
    .id_rs2_used_i   (id_rs2_used_i),
    .ex_rd_i         (ex_rd_i),
    .ex_reg_wr_i     (ex_reg_wr_i),
    .ex_load_i       (ex_load_i),
    .br_mispredict_i (br_mispredict_i),
    .halt_req_i      (halt_req_i),
    .step_i          (step_i),
    .resume_i        (resume_i),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_stall_o   (id_ex_stall_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .halted_o        (halted_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: operating mode, remaining drain cycles, halted flag, plain int counters.
  typedef enum {M_RUN, M_DRAIN, M_HALTED, M_STEP} mode_t;
  mode_t m_mode;
  int    m_left;
  bit    m_halted;
  int    m_stall;
  int    m_flush;

  function automatic bit hz();
    return ex_load_i && ex_reg_wr_i && (ex_rd_i != 0) &&
           ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
  endfunction

  // Packed as {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, halted, stall_cnt, flush_cnt}.
  function automatic logic [13:0] exp_v();
    logic [4:0] o;
    o = 5'b00000;
    if (reset_n) begin
      case (m_mode)
        M_RUN, M_STEP: begin
          if (br_mispredict_i) o = 5'b00101;
          else if (hz())       o = 5'b11010;
        end
        M_DRAIN:  o = br_mispredict_i ? 5'b00101 : 5'b11010;
        M_HALTED: o = 5'b11010;
        default:  o = 5'b00000;
      endcase
    end
    return {o, m_halted, 4'(m_stall), 4'(m_flush)};
  endfunction

  function automatic logic [13:0] obs_v();
    return {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
            halted_o, stall_cnt_o, flush_cnt_o};
  endfunction

  task automatic model_reset();
    m_mode   = M_RUN;
    m_left   = 0;
    m_halted = 0;
    m_stall  = 0;
    m_flush  = 0;
  endtask

  // Advance the model on a rising edge using the inputs that were stable before it.
  task automatic tick();
    mode_t prev;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      prev = m_mode;
      if (br_mispredict_i) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if ((m_mode == M_RUN || m_mode == M_STEP) && !br_mispredict_i && hz())
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      case (m_mode)
        M_RUN:    if (halt_req_i) begin m_mode = M_DRAIN; m_left = D; end
        M_DRAIN:  begin
          if (m_left == 1) m_mode = M_HALTED;
          m_left = m_left - 1;
        end
        M_HALTED: begin
          if (resume_i)    m_mode = M_RUN;
          else if (step_i) m_mode = M_STEP;
        end
        M_STEP:   if (!(hz() && !br_mispredict_i)) begin m_mode = M_DRAIN; m_left = D; end
        default:  m_mode = M_RUN;
      endcase
      m_halted = (prev == M_HALTED) && (m_mode == M_HALTED);
    end
    #1;
  endtask

  task automatic clear_in();
    id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
    id_rs1_used_i = 0; id_rs2_used_i = 0; ex_reg_wr_i = 0; ex_load_i = 0;
    br_mispredict_i = 0; halt_req_i = 0; step_i = 0; resume_i = 0;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    ex_load_i = 1; ex_reg_wr_i = 1; ex_rd_i = rd;
    id_rs2_i = rd; id_rs2_used_i = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    clear_in();
    set_hazard(5'd5);
    br_mispredict_i = 1;
    #1;
    if (obs_v() !== 14'h0) begin
      failures++; $display("FAIL reset_outputs got=%b want=%b", obs_v(), 14'h0);
    end
    checks++;
    tick();
    tick();
    reset_n = 1;
    clear_in();
    #1;
    if (obs_v() !== exp_v()) begin
      failures++; $display("FAIL reset_release got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
  endtask

  task automatic test_load_use();
    set_hazard(5'd5);
    #1;
    if (obs_v()[13:9] !== 5'b11010 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL load_use_stall got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    clear_in();
    #1;
    if (stall_cnt_o !== 4'd1 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL load_use_count got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    set_hazard(5'd0);
    #1;
    if (obs_v()[13:9] !== 5'b00000 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL load_use_x0 got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    clear_in();
  endtask

  task automatic test_mispredict();
    set_hazard(5'd5);
    br_mispredict_i = 1;
    #1;
    if (obs_v()[13:9] !== 5'b00101 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL mispredict_priority got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    clear_in();
    #1;
    if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd1 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL mispredict_counts got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
  endtask

  task automatic test_halt_resume();
    halt_req_i = 1;
    #1;
    if (obs_v() !== exp_v()) begin
      failures++; $display("FAIL halt_req_cycle got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    halt_req_i = 0;
    for (int e = 1; e <= 5; e++) begin
      #1;
      if (obs_v()[13:8] !== {5'b11010, (e >= 5)} || obs_v() !== exp_v()) begin
        failures++; $display("FAIL halt_edge%0d got=%b want=%b", e, obs_v(), exp_v());
      end
      checks++;
      if (e < 5) tick();
    end
    resume_i = 1;
    tick();
    resume_i = 0;
    #1;
    if (obs_v()[13:8] !== 6'b000000 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL resume got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
  endtask

  task automatic test_single_step();
    halt_req_i = 1;
    tick();
    halt_req_i = 0;
    for (int i = 0; i < 5; i++) tick();
    step_i = 1;
    tick();
    step_i = 0;
    #1;
    if (obs_v()[13:8] !== 6'b000000 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL step_cycle got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      if (obs_v() !== exp_v()) begin
        failures++; $display("FAIL step_drain%0d got=%b want=%b", i, obs_v(), exp_v());
      end
      checks++;
    end
    if (halted_o !== 1'b1) begin
      failures++; $display("FAIL step_rehalted got=%b want=1", halted_o);
    end
    checks++;
    step_i = 1;
    tick();
    step_i = 0;
    set_hazard(5'd7);
    #1;
    if (obs_v()[13:9] !== 5'b11010 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL step_hazard got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    clear_in();
    #1;
    if (obs_v()[13:9] !== 5'b00000 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL step_repeat got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_back_to_back();
    halt_req_i = 1;
    resume_i = 1;
    tick();
    resume_i = 0;
    #1;
    if (obs_v()[13:8] !== 6'b000000 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL held_halt_run got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    halt_req_i = 0;
    #1;
    if (obs_v()[13:9] !== 5'b11010 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL held_halt_redrain got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    for (int i = 0; i < 5; i++) tick();
    resume_i = 1;
    tick();
    resume_i = 0;
    halt_req_i = 1;
    br_mispredict_i = 1;
    #1;
    if (obs_v()[13:9] !== 5'b00101 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL halt_with_mispredict got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    clear_in();
    #1;
    if (obs_v() !== exp_v()) begin
      failures++; $display("FAIL halt_mispredict_drain got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
  endtask

  task automatic test_saturation();
    reset_n = 0;
    model_reset();
    #1;
    reset_n = 1;
    tick();
    br_mispredict_i = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (obs_v() !== exp_v()) begin
        failures++; $display("FAIL saturate_cycle%0d got=%b want=%b", i, obs_v(), exp_v());
      end
      checks++;
      tick();
    end
    br_mispredict_i = 0;
    #1;
    if (flush_cnt_o !== 4'd15) begin
      failures++; $display("FAIL flush_saturated got=%0d want=15", flush_cnt_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid_drain();
    set_hazard(5'd9);
    tick();
    clear_in();
    halt_req_i = 1;
    tick();
    halt_req_i = 0;
    tick();
    set_hazard(5'd3);
    br_mispredict_i = 1;
    #1;
    reset_n = 0;
    model_reset();
    #1;
    if (obs_v() !== 14'h0) begin
      failures++; $display("FAIL reset_in_drain got=%b want=%b", obs_v(), 14'h0);
    end
    checks++;
    tick();
    reset_n = 1;
    clear_in();
    set_hazard(5'd3);
    #1;
    if (obs_v()[13:9] !== 5'b11010 || obs_v()[7:0] !== 8'h00 || obs_v() !== exp_v()) begin
      failures++; $display("FAIL reset_back_to_run got=%b want=%b", obs_v(), exp_v());
    end
    checks++;
    tick();
    clear_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 99) == 0) begin
        reset_n = 0;
        model_reset();
      end
      ex_rd_i         = 5'($urandom_range(0, 3));
      id_rs1_i        = 5'($urandom_range(0, 3));
      id_rs2_i        = 5'($urandom_range(0, 3));
      id_rs1_used_i   = 1'($urandom_range(0, 1));
      id_rs2_used_i   = 1'($urandom_range(0, 1));
      ex_load_i       = 1'($urandom_range(0, 1));
      ex_reg_wr_i     = ($urandom_range(0, 3) != 0);
      br_mispredict_i = ($urandom_range(0, 6) == 0);
      halt_req_i      = ($urandom_range(0, 15) == 0);
      step_i          = ($urandom_range(0, 4) == 0);
      resume_i        = ($urandom_range(0, 9) == 0);
      #1;
      if (obs_v() !== exp_v()) begin
        failures++; $display("FAIL random_cycle%0d got=%b want=%b", i, obs_v(), exp_v());
      end
      checks++;
      tick();
    end
    reset_n = 1;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_halt_resume();
    test_single_step();
    test_back_to_back();
    test_saturation();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
